emergency_lane_arbiter: RTL and testbench

Conditions the eight raw per-lane emergency-vehicle beacons and produces the `emgSignal` / `emgLane` pair consumed by `Breadboard`. It sits directly upstream of the traffic-light controller. It synchronises and debounces each beacon, grants exactly one lane at a time, enforces a minimum grant duration, and inserts a clearance gap between consecutive grants. Bit ordering of all 8-bit vectors matches the controller's packed lane bus: bit 7 = w1, 6 = w2, 5 = s1, 4 = s2, 3 = e1, 2 = e2, 1 = n1, 0 = n2.

---
 rtl/emergency_lane_arbiter.sv | 111 +++++++++++
 tb/tb_emergency_lane_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/emergency_lane_arbiter.sv
// emergency_lane_arbiter: sync/debounce 8 beacons, grant one lane with hold minimum and clearance gap
// Define ROUND_ROBIN_EN for rotating priority; default is lowest-index fixed priority.
module emergency_lane_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES = 40,
  parameter int CLEAR_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] emgRaw,
  output logic       emgSignal,
  output logic [7:0] emgLane,
  output logic       emgPending
);
  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;
  state_t state, state_n;
  logic [7:0] s1, s2, req, pick, mask, mask_n, lane_n, hold, hold_n, clr, clr_n;
  logic [7:0] cnt [8];
  logic sig_n, pend_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      req <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      s1 <= emgRaw;
      s2 <= s1;
      for (int i = 0; i < 8; i++) begin
        if (s2[i] == req[i]) cnt[i] <= '0;
        else if (cnt[i] >= 8'(DEBOUNCE_CYCLES - 1)) begin
          req[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end
`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr, idx, j;
  // Search starts just past the last granted lane and wraps back to it
  always_comb begin
    pick = '0;
    idx = ptr;
    j = '0;
    for (int k = 1; k <= 8; k++) begin
      j = ptr + 3'(k);
      if (pick == '0 && req[j]) begin
        pick = 8'd1 << j;
        idx = j;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= 3'd7;
    else if (state == IDLE && |req) ptr <= idx;
  end
`else
  assign pick = req & (~req + 8'd1);
`endif
  always_comb begin
    state_n = state;
    lane_n = emgLane;
    sig_n = emgSignal;
    hold_n = hold;
    clr_n = clr;
    mask_n = mask;
    case (state)
      IDLE: if (|req) begin
        state_n = GRANT;
        lane_n = pick;
        sig_n = 1'b1;
        hold_n = 8'd1;
        mask_n = pick;
      end
      GRANT: begin
        hold_n = hold >= 8'(HOLD_CYCLES) ? hold : hold + 8'd1;
        if (hold >= 8'(HOLD_CYCLES) && !(|(req & emgLane))) begin
          state_n = CLEAR;
          lane_n = '0;
          sig_n = 1'b0;
          clr_n = 8'd1;
        end
      end
      CLEAR: begin
        clr_n = clr + 8'd1;
        if (clr >= 8'(CLEAR_CYCLES)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    pend_n = state_n == IDLE ? |req : |(req & ~mask_n);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      emgLane <= '0;
      emgSignal <= 1'b0;
      emgPending <= 1'b0;
      hold <= '0;
      clr <= '0;
      mask <= '0;
    end else begin
      state <= state_n;
      emgLane <= lane_n;
      emgSignal <= sig_n;
      emgPending <= pend_n;
      hold <= hold_n;
      clr <= clr_n;
      mask <= mask_n;
    end
  end
endmodule

// File: tb/tb_emergency_lane_arbiter.sv
// tb_emergency_lane_arbiter: segment table with per-edge scoreboard plus timed corner sequences
module tb_emergency_lane_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] emgRaw = '0;
  logic emgSignal, emgPending;
  logic [7:0] emgLane;
  int tests = 0, fails = 0;
  typedef struct {logic r; logic [7:0] raw; int n; logic sig; logic [7:0] lane; logic pend;} vec_t;
  typedef struct {logic sig; logic [7:0] lane; logic pend; int id;} exp_t;
  vec_t tbl [23];
  exp_t q [$];
  exp_t e;
  emergency_lane_arbiter dut (
    .clk(clk), .rst(rst), .emgRaw(emgRaw),
    .emgSignal(emgSignal), .emgLane(emgLane), .emgPending(emgPending)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input logic r, input logic [7:0] raw);
    @(negedge clk);
    rst = r;
    emgRaw = raw;
    @(posedge clk);
    #1;
    check("sig_eq_or_lane_onehot", {emgSignal == |emgLane, $onehot0(emgLane)}, 2'b11);
  endtask
  task automatic seg(input vec_t v, input int id);
    for (int c = 0; c < v.n; c++) begin
      @(negedge clk);
      rst = v.r;
      emgRaw = v.raw;
      q.push_back('{v.sig, v.lane, v.pend, id});
      @(posedge clk);
      #1;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL vec%0d: scoreboard empty", id);
      end else begin
        e = q.pop_front();
        if ({emgSignal, emgLane, emgPending} !== {e.sig, e.lane, e.pend}) begin
          fails++;
          $display("FAIL vec%0d cyc%0d: sig/lane/pend=%b/%h/%b expected %b/%h/%b",
                   e.id, c, emgSignal, emgLane, emgPending, e.sig, e.lane, e.pend);
        end
      end
    end
  endtask
  initial begin
    int lat, width, gap, n;
    logic [7:0] rr_lane;
    tbl[0]  = '{1'b1, 8'hFF, 2,  1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 10, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h08, 6,  1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h08, 54, 1'b1, 8'h08, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 6,  1'b1, 8'h08, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 20, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h08, 3,  1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 12, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 8'h01, 6,  1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'h01, 4,  1'b1, 8'h01, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 36, 1'b1, 8'h01, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 15, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 8'h24, 6,  1'b0, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 8'h24, 54, 1'b1, 8'h04, 1'b1};
    tbl[14] = '{1'b0, 8'h20, 6,  1'b1, 8'h04, 1'b1};
    tbl[15] = '{1'b0, 8'h20, 11, 1'b0, 8'h00, 1'b1};
    tbl[16] = '{1'b0, 8'h20, 10, 1'b1, 8'h20, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 30, 1'b1, 8'h20, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 15, 1'b0, 8'h00, 1'b0};
    tbl[19] = '{1'b0, 8'h08, 6,  1'b0, 8'h00, 1'b0};
    tbl[20] = '{1'b0, 8'h08, 3,  1'b1, 8'h08, 1'b0};
    tbl[21] = '{1'b1, 8'h08, 1,  1'b0, 8'h00, 1'b0};
    tbl[22] = '{1'b0, 8'h00, 10, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 23; i++) seg(tbl[i], i);
    lat = 0;
    do begin
      lat++;
      tick(1'b0, lat <= 5 ? 8'h80 : 8'h00);
    end while (!emgSignal && lat < 30);
    check("assert_latency", lat, 7);
    check("latency_lane", int'(emgLane), 8'h80);
    width = 0;
    while (emgSignal && width < 100) begin
      tick(1'b0, 8'h01);
      width++;
    end
    check("hold_width", width, 40);
    gap = 1;
    while (!emgSignal && gap < 40) begin
      tick(1'b0, 8'h01);
      if (!emgSignal) gap++;
    end
    check("clear_gap", gap, 11);
    check("gap_lane", int'(emgLane), 8'h01);
    for (int k = 0; k < 70; k++) tick(1'b0, 8'h00);
    check("idle_after_release", int'(emgSignal), 0);
`ifdef ROUND_ROBIN_EN
    rr_lane = 8'h20;
`else
    rr_lane = 8'h01;
`endif
    n = 0;
    do begin
      n++;
      tick(1'b0, 8'h21);
    end while (!emgSignal && n < 30);
    check("arb_lane", int'(emgLane), int'(rr_lane));
    check("arb_pending", int'(emgPending), 1);
    tick(1'b1, 8'h21);
    check("midgrant_reset", int'({emgSignal, emgLane, emgPending}), 0);
    n = 0;
    do begin
      n++;
      tick(1'b0, 8'h21);
    end while (!emgSignal && n < 30);
    check("post_reset_latency", n, 7);
    check("post_reset_lane", int'(emgLane), 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
